// File: rtl/memory_bridge.sv
`default_nettype none
// ============================================================================
// Module  : memory_bridge
// Brief   : Core byte-addressed request bus to word RAM bridge with lane
//           steering, misalignment faults and configurable RAM wait states.
// Rev     : 1.0  initial release
// ============================================================================
module memory_bridge #(
  parameter int WAIT_STATES = 0,
  parameter int RAM_AW      = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr,
  inout  wire  [31:0]       mem_data,
  input  logic              mem_rw,
  input  logic [1:0]        mem_size,
  output logic              mem_ready,
  output logic              mem_fault,
  output logic              ram_req,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [2:0] c_WS_LAST = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  state_t              state_q;
  logic [31:0]         addr_q;
  logic                rw_q;
  logic [1:0]          size_q;
  logic [2:0]          wcnt_q;
  logic [31:0]         rdata_q;
  logic                mem_ready_q;
  logic                mem_fault_q;
  logic                ram_req_q;
  logic                ram_we_q;
  logic [RAM_AW-1:0]   ram_addr_q;
  logic [3:0]          ram_be_q;
  logic [31:0]         ram_wdata_q;

  logic                w_misaligned;
  logic                w_changed;
  logic                w_drive;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [31:0]         w_shift;
  logic [31:0]         w_rdata;

  assign w_misaligned = ((mem_size == 2'd2) && mem_addr[0]) ||
                        ((mem_size == 2'd3) && (mem_addr[1:0] != 2'b00));

  assign w_changed = (mem_size == 2'd0) || (mem_addr != addr_q) ||
                     (mem_rw != rw_q) || (mem_size != size_q);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_data;
    case (mem_size)
      2'd1: begin
        w_be    = 4'b0001 << mem_addr[1:0];
        w_wdata = {4{mem_data[7:0]}};
      end
      2'd2: begin
        w_be    = 4'b0011 << mem_addr[1:0];
        w_wdata = {2{mem_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = mem_data;
      end
    endcase
  end

  // Halfwords are aligned here, so a byte-granular shift also selects the right pair.
  assign w_shift = ram_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    w_rdata = ram_rdata;
    case (size_q)
      2'd1:    w_rdata = {24'd0, w_shift[7:0]};
      2'd2:    w_rdata = {16'd0, w_shift[15:0]};
      default: w_rdata = ram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'd0;
      rw_q        <= 1'b0;
      size_q      <= 2'd0;
      wcnt_q      <= 3'd0;
      rdata_q     <= 32'd0;
      mem_ready_q <= 1'b0;
      mem_fault_q <= 1'b0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_be_q    <= 4'd0;
      ram_wdata_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_size != 2'd0) begin
            addr_q <= mem_addr;
            rw_q   <= mem_rw;
            size_q <= mem_size;
            if (w_misaligned) begin
              state_q     <= S_FAULT;
              mem_ready_q <= 1'b1;
              mem_fault_q <= 1'b1;
              rdata_q     <= 32'd0;
            end else begin
              state_q     <= S_ACCESS;
              ram_req_q   <= 1'b1;
              ram_we_q    <= mem_rw;
              ram_addr_q  <= mem_addr[RAM_AW+1:2];
              ram_be_q    <= w_be;
              ram_wdata_q <= w_wdata;
            end
          end
        end
        S_ACCESS: begin
          ram_req_q   <= 1'b0;
          ram_we_q    <= 1'b0;
          ram_addr_q  <= '0;
          ram_be_q    <= 4'd0;
          ram_wdata_q <= 32'd0;
          if (WAIT_STATES == 0) begin
            rdata_q     <= w_rdata;
            mem_ready_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            wcnt_q  <= c_WS_LAST;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wcnt_q == 3'd0) begin
            rdata_q     <= w_rdata;
            mem_ready_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            wcnt_q <= wcnt_q - 3'd1;
          end
        end
        S_DONE, S_FAULT: begin
          // Completion is held until the core drops or alters its request.
          if (w_changed) begin
            state_q     <= S_IDLE;
            mem_ready_q <= 1'b0;
            mem_fault_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign w_drive = ((state_q == S_DONE) || (state_q == S_FAULT)) && !rw_q &&
                   (mem_size != 2'd0);

  assign mem_data  = w_drive ? rdata_q : {32{1'bz}};
  assign mem_ready = mem_ready_q;
  assign mem_fault = mem_fault_q;
  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_be    = ram_be_q;
  assign ram_wdata = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_memory_bridge
// Brief   : Bench for memory_bridge with zero and three wait states, using a
//           byte-array reference memory and request-level expectations.
// Rev     : 1.0  initial release
// ============================================================================
module tb_memory_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a   = 32'd0;
  logic        rw  = 1'b0;
  logic [1:0]  sz  = 2'd0;
  logic        drv = 1'b0;
  logic [31:0] wd  = 32'd0;
  logic        sel = 1'b0;

  always #5 clk = ~clk;

  wire [31:0] md0;
  wire [31:0] md3;
  assign md0 = (drv && !sel) ? wd : {32{1'bz}};
  assign md3 = (drv &&  sel) ? wd : {32{1'bz}};

  logic        rdy0, flt0, req0, we0, rdy3, flt3, req3, we3;
  logic [13:0] ra0, ra3;
  logic [3:0]  be0, be3;
  logic [31:0] wdat0, wdat3, rdat0, rdat3;

  memory_bridge #(.WAIT_STATES(0), .RAM_AW(14)) u_dut0 (
    .clk(clk), .rst(rst), .mem_addr(a), .mem_data(md0), .mem_rw(rw),
    .mem_size(sz), .mem_ready(rdy0), .mem_fault(flt0), .ram_req(req0),
    .ram_we(we0), .ram_addr(ra0), .ram_be(be0), .ram_wdata(wdat0),
    .ram_rdata(rdat0)
  );

  memory_bridge #(.WAIT_STATES(3), .RAM_AW(14)) u_dut3 (
    .clk(clk), .rst(rst), .mem_addr(a), .mem_data(md3), .mem_rw(rw),
    .mem_size(sz), .mem_ready(rdy3), .mem_fault(flt3), .ram_req(req3),
    .ram_we(we3), .ram_addr(ra3), .ram_be(be3), .ram_wdata(wdat3),
    .ram_rdata(rdat3)
  );

  logic        o_rdy, o_flt, o_req, o_we;
  logic [13:0] o_ra;
  logic [3:0]  o_be;
  logic [31:0] o_wdat, o_md;
  assign o_rdy  = sel ? rdy3  : rdy0;
  assign o_flt  = sel ? flt3  : flt0;
  assign o_req  = sel ? req3  : req0;
  assign o_we   = sel ? we3   : we0;
  assign o_ra   = sel ? ra3   : ra0;
  assign o_be   = sel ? be3   : be0;
  assign o_wdat = sel ? wdat3 : wdat0;
  assign o_md   = sel ? md3   : md0;

  // Environment RAM: 16 words, written by whichever bridge is selected.
  logic [31:0] env_ram [16];
  logic [3:0]  lat0 = 4'd0;
  logic [3:0]  lat3 = 4'd0;
  assign rdat0 = req0 ? env_ram[ra0[3:0]] : env_ram[lat0];
  assign rdat3 = req3 ? env_ram[ra3[3:0]] : env_ram[lat3];

  int          req_cnt = 0;
  logic [13:0] cap_ra  = 14'd0;
  logic [3:0]  cap_be  = 4'd0;
  logic        cap_we  = 1'b0;
  logic [31:0] cap_wd  = 32'd0;

  always @(posedge clk) begin
    if (req0) lat0 <= ra0[3:0];
    if (req3) lat3 <= ra3[3:0];
    if (o_req) begin
      req_cnt <= req_cnt + 1;
      cap_ra  <= o_ra;
      cap_be  <= o_be;
      cap_we  <= o_we;
      cap_wd  <= o_wdat;
      if (o_we) begin
        for (int i = 0; i < 4; i++)
          if (o_be[i]) env_ram[o_ra[3:0]][8*i +: 8] <= o_wdat[8*i +: 8];
      end
    end
  end

  // Reference model state: what the RAM should hold, as plain bytes.
  logic [7:0] ref_bytes [64];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_misaligned(input logic [1:0] s, input logic [31:0] ad);
    int nbytes;
    nbytes = (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : 4;
    return (ad % nbytes) != 0;
  endfunction

  task automatic drop();
    sz  = 2'd0;
    drv = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_req(input logic [31:0] ad, input logic r_w, input logic [1:0] s,
                        input logic [31:0] wdata, input int hold, input bit b2b,
                        output logic [31:0] rd);
    int          ws, lat, n, c0, nbytes, base;
    bit          flt, got;
    logic [31:0] expv, exp_rep;
    logic [3:0]  exp_be;
    ws     = sel ? 3 : 0;
    flt    = is_misaligned(s, ad);
    lat    = (flt ? 1 : 2 + ws) + (b2b ? 1 : 0);
    nbytes = (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : 4;
    base   = int'(ad[5:0]);
    c0     = req_cnt;
    a = ad; rw = r_w; sz = s; wd = wdata; drv = r_w;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = o_rdy;
    end
    check_val("latency", n, lat);
    check_val("fault_flag", {31'd0, o_flt}, {31'd0, flt});
    rd = o_md;
    if (!r_w) begin
      expv = 32'd0;
      if (!flt)
        for (int k = 0; k < nbytes; k++) expv = expv + (32'(ref_bytes[base + k]) << (8 * k));
      check_val("read_data", rd, expv);
    end else if (!flt) begin
      for (int k = 0; k < nbytes; k++) ref_bytes[base + k] = wdata[8*k +: 8];
    end
    repeat (hold) @(negedge clk);
    check_val("ready_held", {31'd0, o_rdy}, 32'd1);
    check_val("ram_cycles", req_cnt - c0, flt ? 0 : 1);
    if (!flt) begin
      exp_be  = 4'd0;
      for (int k = 0; k < nbytes; k++) exp_be[(base % 4) + k] = 1'b1;
      exp_rep = (s == 2'd1) ? wdata[7:0] * 32'h01010101 :
                (s == 2'd2) ? wdata[15:0] * 32'h00010001 : wdata;
      check_val("ram_addr", {18'd0, cap_ra}, ad / 4);
      check_val("ram_be", {28'd0, cap_be}, {28'd0, exp_be});
      check_val("ram_we", {31'd0, cap_we}, {31'd0, r_w});
      if (r_w) check_val("ram_wdata", cap_wd, exp_rep);
    end
  endtask

  task automatic run_random(input int nt);
    bit          prev_read, b2b, r_w;
    logic [31:0] ad, prev_ad, wdata, d;
    logic [1:0]  s, prev_s;
    int          hold;
    prev_read = 0; prev_ad = 0; prev_s = 0;
    for (int t = 0; t < nt; t++) begin
      ad    = 32'($urandom_range(0, 63));
      s     = 2'($urandom_range(1, 3));
      r_w   = 1'($urandom_range(0, 1));
      wdata = $urandom;
      hold  = $urandom_range(0, 3);
      b2b   = prev_read && !r_w && (ad != prev_ad || s != prev_s) && ($urandom_range(0, 1) == 1);
      if (!b2b) drop();
      do_req(ad, r_w, s, wdata, hold, b2b, d);
      prev_read = !r_w; prev_ad = ad; prev_s = s;
    end
    drop();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          c0, hi;
    repeat (3) @(negedge clk);
    check_val("rst_ready0", {31'd0, rdy0}, 32'd0);
    check_val("rst_fault0", {31'd0, flt0}, 32'd0);
    check_val("rst_req0",   {31'd0, req0}, 32'd0);
    check_val("rst_we0",    {31'd0, we0},  32'd0);
    check_val("rst_addr0",  {18'd0, ra0},  32'd0);
    check_val("rst_be0",    {28'd0, be0},  32'd0);
    check_val("rst_wdata0", wdat0,         32'd0);
    check_val("rst_ready3", {31'd0, rdy3}, 32'd0);
    check_val("rst_req3",   {31'd0, req3}, 32'd0);
    rst = 1'b0;

    // Fill RAM with known words so every later read has a defined expectation.
    for (int i = 0; i < 16; i++) begin
      do_req(32'(4 * i), 1'b1, 2'd3, $urandom, 0, 1'b0, d);
      drop();
    end
    do_req(32'h10, 1'b1, 2'd3, 32'hDEADBEEF, 0, 1'b0, d);
    drop();

    do_req(32'h10, 1'b0, 2'd3, 32'd0, 0, 1'b0, d);
    check_val("word_read_data", d, 32'hDEADBEEF);
    check_val("word_read_addr", {18'd0, cap_ra}, 32'd4);
    check_val("word_read_be", {28'd0, cap_be}, 32'hF);
    drop();

    do_req(32'h13, 1'b0, 2'd1, 32'd0, 0, 1'b0, d);
    check_val("byte_read_data", d, 32'h000000DE);
    check_val("byte_read_be", {28'd0, cap_be}, 32'h8);
    drop();

    do_req(32'h6, 1'b1, 2'd2, 32'h0000ABCD, 6, 1'b0, d);
    check_val("half_write_we", {31'd0, cap_we}, 32'd1);
    check_val("half_write_be", {28'd0, cap_be}, 32'hC);
    check_val("half_write_wdata", cap_wd, 32'hABCDABCD);
    check_val("half_write_addr", {18'd0, cap_ra}, 32'd1);
    drop();

    c0 = req_cnt;
    do_req(32'h2, 1'b0, 2'd3, 32'd0, 2, 1'b0, d);
    check_val("fault_data", d, 32'd0);
    check_val("fault_no_ram", req_cnt - c0, 0);
    drop();

    c0 = req_cnt;
    do_req(32'h0, 1'b0, 2'd1, 32'd0, 1, 1'b0, d);
    do_req(32'h1, 1'b0, 2'd1, 32'd0, 1, 1'b1, d);
    check_val("b2b_two_cycles", req_cnt - c0, 2);
    drop();

    run_random(80);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    sel = 1'b1;
    rst = 1'b0;

    do_req(32'h10, 1'b0, 2'd3, 32'd0, 1, 1'b0, d);
    check_val("ws3_word_data", d, 32'hDEADBEEF);
    drop();

    // Abort a three-wait-state read with reset during its first wait cycle.
    c0 = req_cnt;
    a = 32'h20; rw = 1'b0; sz = 2'd3; drv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sz  = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    hi  = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_rdy) hi++;
    end
    check_val("rst_abort_ready", hi, 0);
    check_val("rst_abort_ram_once", req_cnt - c0, 1);

    run_random(30);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
